// File: rtl/sdram_sram_copy.sv
// sdram_sram_copy: copies iLen words from SDRAM to SRAM, one word at a time.
// Each word is a read request on the SDRAM side, a wait for the read data,
// then a write request on the SRAM side and a wait for the arbiter to finish
// the write (busy seen high, then low). Every output comes straight from a flop.
module sdram_sram_copy #(
    parameter int SRC_STEP = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [22:0] iSrc_addr,
    input  logic [17:0] iDst_addr,
    input  logic [15:0] iLen,
    input  logic        iBusy,
    input  logic [15:0] iRdata,
    input  logic        iRdata_valid,
    output logic        oSDRAM_valid,
    output logic        oSDRAM_rd_Nwr,
    output logic [22:0] oSDRAM_addr,
    output logic [15:0] oSDRAM_data,
    output logic        oSRAM_valid,
    output logic        oSRAM_rd_Nwr,
    output logic [17:0] oSRAM_addr,
    output logic [15:0] oSRAM_data,
    output logic        oActive,
    output logic        oDone,
    output logic [15:0] oCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [22:0] src_reg, src_next;
    logic [17:0] dst_reg, dst_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] count_reg, count_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        seen_busy_reg, seen_busy_next;
    logic        sdram_valid_reg, sdram_valid_next;
    logic        sram_valid_reg, sram_valid_next;
    logic        done_reg, done_next;
    logic        active_reg, active_next;

    logic [15:0] count_inc;
    assign count_inc = count_reg + 16'd1;

    // Next-state and next-output logic; request valids are computed for the
    // state being entered so they appear in the same cycle as that state.
    always_comb begin
        state_next       = state_reg;
        src_next         = src_reg;
        dst_next         = dst_reg;
        len_next         = len_reg;
        count_next       = count_reg;
        wdata_next       = wdata_reg;
        seen_busy_next   = seen_busy_reg;
        sdram_valid_next = 1'b0;
        sram_valid_next  = 1'b0;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (iStart) begin
                    count_next = 16'd0;
                    if (iLen != 16'd0) begin
                        src_next         = iSrc_addr;
                        dst_next         = iDst_addr;
                        len_next         = iLen;
                        state_next       = RD_REQ;
                        sdram_valid_next = 1'b1;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                // valid is always high here, so a low busy means acceptance
                if (!iBusy) begin
                    state_next = RD_WAIT;
                end else begin
                    sdram_valid_next = 1'b1;
                end
            end
            RD_WAIT: begin
                if (iRdata_valid) begin
                    wdata_next      = iRdata;
                    state_next      = WR_REQ;
                    sram_valid_next = 1'b1;
                end
            end
            WR_REQ: begin
                if (!iBusy) begin
                    state_next     = WR_WAIT;
                    seen_busy_next = 1'b0;
                end else begin
                    sram_valid_next = 1'b1;
                end
            end
            WR_WAIT: begin
                if (iBusy) begin
                    seen_busy_next = 1'b1;
                end else if (seen_busy_reg) begin
                    count_next = count_inc;
                    src_next   = src_reg + 23'(SRC_STEP);
                    dst_next   = dst_reg + 18'd1;
                    if (count_inc == len_reg) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next       = RD_REQ;
                        sdram_valid_next = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        active_next = (state_next != IDLE);
    end

    // State and output registers; reset clears everything including oCount.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg       <= IDLE;
            src_reg         <= 23'd0;
            dst_reg         <= 18'd0;
            len_reg         <= 16'd0;
            count_reg       <= 16'd0;
            wdata_reg       <= 16'd0;
            seen_busy_reg   <= 1'b0;
            sdram_valid_reg <= 1'b0;
            sram_valid_reg  <= 1'b0;
            done_reg        <= 1'b0;
            active_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            src_reg         <= src_next;
            dst_reg         <= dst_next;
            len_reg         <= len_next;
            count_reg       <= count_next;
            wdata_reg       <= wdata_next;
            seen_busy_reg   <= seen_busy_next;
            sdram_valid_reg <= sdram_valid_next;
            sram_valid_reg  <= sram_valid_next;
            done_reg        <= done_next;
            active_reg      <= active_next;
        end
    end

    assign oSDRAM_valid  = sdram_valid_reg;
    assign oSDRAM_rd_Nwr = sdram_valid_reg;   // this block only ever reads SDRAM
    assign oSDRAM_addr   = src_reg;
    assign oSDRAM_data   = 16'd0;
    assign oSRAM_valid   = sram_valid_reg;
    assign oSRAM_rd_Nwr  = 1'b0;              // this block only ever writes SRAM
    assign oSRAM_addr    = dst_reg;
    assign oSRAM_data    = wdata_reg;
    assign oActive       = active_reg;
    assign oDone         = done_reg;
    assign oCount        = count_reg;

endmodule

// File: tb/tb_sdram_sram_copy.sv
// Bench for sdram_sram_copy: an arbiter/memory model answers requests, logs
// accepted reads and writes, and each copy is compared with the list of
// transfers computed directly from source, destination and length.
module tb_sdram_sram_copy;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [22:0] src_in = '0;
    logic [17:0] dst_in = '0;
    logic [15:0] len_in = '0;
    logic        busy;
    logic [15:0] rdata;
    logic        rvalid;

    logic        sd_valid, sd_rdnwr, sr_valid, sr_rdnwr, active, done;
    logic [22:0] sd_addr;
    logic [15:0] sd_data, sr_data, count;
    logic [17:0] sr_addr;

    sdram_sram_copy #(.SRC_STEP(STEP)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start),
        .iSrc_addr(src_in), .iDst_addr(dst_in), .iLen(len_in),
        .iBusy(busy), .iRdata(rdata), .iRdata_valid(rvalid),
        .oSDRAM_valid(sd_valid), .oSDRAM_rd_Nwr(sd_rdnwr),
        .oSDRAM_addr(sd_addr), .oSDRAM_data(sd_data),
        .oSRAM_valid(sr_valid), .oSRAM_rd_Nwr(sr_rdnwr),
        .oSRAM_addr(sr_addr), .oSRAM_data(sr_data),
        .oActive(active), .oDone(done), .oCount(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // arbiter/memory model configuration
    logic [15:0] offset = 16'h0;
    int  bp_max = 0;
    int  wr_busy = 2;
    int  force_hold = -1;
    int  rd_lat_force = 0;
    bit  junk_en = 1'b0;

    logic [22:0] rd_q[$];
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    int  done_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {33'd0, sd_valid, sd_rdnwr, sd_addr, sd_data, sr_valid, sr_rdnwr,
                sr_addr, sr_data, active, done, count};
    endfunction

    // reference model: k-th transfer of a copy
    function automatic logic [22:0] exp_rd(input logic [22:0] s, input int k);
        return 23'(s + 23'(k * STEP));
    endfunction
    function automatic logic [17:0] exp_wa(input logic [17:0] d, input int k);
        return 18'(d + 18'(k));
    endfunction
    function automatic logic [15:0] mem_word(input logic [22:0] a);
        return 16'(a) + offset;
    endfunction

    // arbiter and SDRAM/SRAM model, updated on the falling edge
    initial begin
        int rd_cnt;
        int wr_cnt;
        int hold;
        logic [22:0] rd_addr, h_sd;
        logic [17:0] h_sr;
        logic [15:0] h_d;
        rd_cnt = 0; wr_cnt = 0; hold = -1; rd_addr = '0;
        h_sd = '0; h_sr = '0; h_d = '0;
        busy = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            busy = 1'b0;
            rvalid = 1'b0;
            if (rst) begin
                rd_cnt = 0; wr_cnt = 0; hold = -1;
            end else begin
                if (done) done_cnt++;
                check("valid_mutex", sd_valid & sr_valid, 0);
                if (rd_cnt > 0 || wr_cnt > 0)
                    check("outstanding", sd_valid | sr_valid, 0);
                if (hold >= 0) begin
                    check("hold_valid", sd_valid | sr_valid, 1);
                    if (!(sd_valid | sr_valid)) hold = -1;
                end
                if (junk_en && rd_cnt == 0 && $urandom_range(0, 3) == 0) begin
                    rvalid = 1'b1;
                    rdata  = 16'hDEAD;
                end
                if (wr_cnt > 0) begin
                    busy = 1'b1;
                    wr_cnt--;
                end else if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        rvalid = 1'b1;
                        rdata  = mem_word(rd_addr);
                    end
                end else if (sd_valid || sr_valid) begin
                    if (hold < 0) begin
                        hold = (force_hold >= 0) ? force_hold : $urandom_range(0, bp_max);
                        force_hold = -1;
                        h_sd = sd_addr; h_sr = sr_addr; h_d = sr_data;
                    end else begin
                        if (sd_valid) check("hold_sd_addr", sd_addr, h_sd);
                        if (sr_valid) begin
                            check("hold_sr_addr", sr_addr, h_sr);
                            check("hold_sr_data", sr_data, h_d);
                        end
                    end
                    if (hold > 0) begin
                        busy = 1'b1;
                        hold--;
                    end else begin
                        hold = -1;
                        if (sd_valid) begin
                            check("rd_dir", sd_rdnwr, 1);
                            check("sd_wdata", sd_data, 0);
                            rd_q.push_back(sd_addr);
                            rd_addr = sd_addr;
                            rd_cnt = (rd_lat_force > 0) ? rd_lat_force : $urandom_range(1, 3);
                        end else begin
                            check("wr_dir", sr_rdnwr, 0);
                            wa_q.push_back(sr_addr);
                            wd_q.push_back(sr_data);
                            wr_cnt = wr_busy;
                        end
                    end
                end
            end
        end
    end

    task automatic start_copy(input logic [22:0] s, input logic [17:0] d, input logic [15:0] l);
        @(negedge clk);
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0;
        src_in = s; dst_in = d; len_in = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_in = 23'($urandom); dst_in = 18'($urandom); len_in = 16'($urandom);
    endtask

    task automatic finish_copy(input string tag, input logic [22:0] s, input logic [17:0] d,
                               input logic [15:0] l);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_active_after"}, active, 0);
        check({tag, "_count"}, count, l);
        check({tag, "_n_reads"}, rd_q.size(), l);
        check({tag, "_n_writes"}, wa_q.size(), l);
        for (int k = 0; k < int'(l); k++) begin
            if (k < rd_q.size()) check({tag, "_rd_addr"}, rd_q[k], exp_rd(s, k));
            if (k < wa_q.size()) begin
                check({tag, "_wr_addr"}, wa_q[k], exp_wa(d, k));
                check({tag, "_wr_data"}, wd_q[k], mem_word(exp_rd(s, k)));
            end
        end
        $display("copy %s src=%06h dst=%05h len=%0d reads=%0d writes=%0d count=%0d",
                 tag, s, d, l, rd_q.size(), wa_q.size(), count);
    endtask

    initial begin
        logic [22:0] s;
        logic [17:0] d;
        logic [15:0] l;
        int n;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;

        // nominal copy
        offset = 16'h9F01; bp_max = 0; wr_busy = 2;
        start_copy(23'h000100, 18'h00200, 16'd3);
        finish_copy("nominal", 23'h000100, 18'h00200, 16'd3);
        if (wd_q.size() == 3) begin
            check("nominal_w0", {wa_q[0], wd_q[0]}, {18'h00200, 16'hA001});
            check("nominal_w1", {wa_q[1], wd_q[1]}, {18'h00201, 16'hA002});
            check("nominal_w2", {wa_q[2], wd_q[2]}, {18'h00202, 16'hA003});
        end

        // zero length: DONE immediately, no bus traffic, count cleared
        start_copy(23'h000055, 18'h00077, 16'd0);
        check("zero_done", done, 1);
        check("zero_active", active, 1);
        check("zero_count", count, 0);
        @(negedge clk);
        check("zero_done_end", done, 0);
        check("zero_idle", active, 0);
        repeat (5) @(negedge clk);
        check("zero_no_reads", rd_q.size(), 0);
        check("zero_no_writes", wa_q.size(), 0);
        $display("copy zero len=0 count=%0d done=%0d", count, done_cnt);

        // wrap-around of both addresses
        start_copy(23'h7FFFFF, 18'h3FFFF, 16'd2);
        finish_copy("wrap", 23'h7FFFFF, 18'h3FFFF, 16'd2);
        if (rd_q.size() == 2) check("wrap_rd1", rd_q[1], 23'h000000);
        if (wa_q.size() == 2) check("wrap_wr1", wa_q[1], 18'h00000);

        // back-pressure on the read request
        force_hold = 10;
        start_copy(23'h001234, 18'h01111, 16'd1);
        finish_copy("backpressure", 23'h001234, 18'h01111, 16'd1);

        // reset during WR_WAIT of word 2 of 4
        start_copy(23'h002000, 18'h02000, 16'd4);
        n = 0;
        while (wa_q.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reached", wa_q.size() >= 2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        $display("copy reset_mid reads=%0d writes=%0d", rd_q.size(), wa_q.size());
        start_copy(23'h003000, 18'h03000, 16'd4);
        finish_copy("after_reset", 23'h003000, 18'h03000, 16'd4);

        // second start during RD_WAIT must be ignored
        rd_lat_force = 3;
        start_copy(23'h004000, 18'h04000, 16'd4);
        n = 0;
        while (rd_q.size() < 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        src_in = 23'h7000AA; dst_in = 18'h1AAAA; len_in = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_lat_force = 0;
        finish_copy("restart_ignored", 23'h004000, 18'h04000, 16'd4);

        // randomized copies
        for (int t = 0; t < 20; t++) begin
            offset  = 16'($urandom);
            bp_max  = $urandom_range(0, 4);
            wr_busy = $urandom_range(1, 3);
            junk_en = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF - 23'($urandom_range(0, 5))
                                            : 23'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 18'h3FFFF - 18'($urandom_range(0, 5))
                                            : 18'($urandom);
            l = 16'($urandom_range(1, 8));
            start_copy(s, d, l);
            finish_copy("random", s, d, l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
